// File: rtl/loader_pkg.sv
// Shared types and defaults for the pattern/text byte-stream loader.
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PATTERN = 2'd1,
        TEXT    = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int unsigned PAT_LEN_DFLT  = 4;
    localparam int unsigned TEXT_MAX_DFLT = 11064;
    localparam int unsigned PAT_AW        = 3;
    localparam int unsigned TXT_AW        = 14;

endpackage

// File: rtl/load_counter.sv
// Up-counter with synchronous clear and enable that saturates at a limit.
module load_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != limit)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/text_loader.sv
// Splits a byte stream into a fixed-length pattern and a zero-terminated,
// capacity-bounded text, emitting registered memory write strobes.
module text_loader
    import loader_pkg::*;
#(
    parameter int unsigned PAT_LEN  = PAT_LEN_DFLT,
    parameter int unsigned TEXT_MAX = TEXT_MAX_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              pat_we,
    output logic [PAT_AW-1:0] pat_addr,
    output logic [7:0]        pat_data,
    output logic              txt_we,
    output logic [TXT_AW-1:0] txt_addr,
    output logic [7:0]        txt_data,
    output logic [TXT_AW-1:0] txt_len,
    output logic              busy,
    output logic              done,
    output logic              full
);

    localparam logic [PAT_AW-1:0] PAT_LIMIT = PAT_AW'(PAT_LEN);
    localparam logic [PAT_AW-1:0] PAT_LAST  = PAT_AW'(PAT_LEN - 1);
    localparam logic [TXT_AW-1:0] TXT_LIMIT = TXT_AW'(TEXT_MAX);
    localparam logic [TXT_AW-1:0] TXT_LAST  = TXT_AW'(TEXT_MAX - 1);

    state_t            state;
    logic              xfer;
    logic              cnt_clr;
    logic              pat_en;
    logic              txt_en;
    logic [PAT_AW-1:0] pat_cnt;

    always_comb begin
        xfer    = in_valid && in_ready;
        cnt_clr = (state == IDLE) && start;
        pat_en  = xfer && (state == PATTERN);
        txt_en  = xfer && (state == TEXT) && (in_data != 8'h00);
    end

    load_counter #(.W(PAT_AW)) u_pat_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (pat_en),
        .limit (PAT_LIMIT),
        .count (pat_cnt)
    );

    load_counter #(.W(TXT_AW)) u_txt_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (txt_en),
        .limit (TXT_LIMIT),
        .count (txt_len)
    );

    // in_ready/busy are registered with the state, so they drop together
    // with the transition into DONE rather than combinationally on the byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            full     <= 1'b0;
            pat_we   <= 1'b0;
            pat_addr <= '0;
            pat_data <= '0;
            txt_we   <= 1'b0;
            txt_addr <= '0;
            txt_data <= '0;
        end else begin
            pat_we <= 1'b0;
            txt_we <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= PATTERN;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        full     <= 1'b0;
                    end
                end
                PATTERN: begin
                    if (xfer) begin
                        pat_we   <= 1'b1;
                        pat_addr <= pat_cnt;
                        pat_data <= in_data;
                        if (pat_cnt == PAT_LAST) begin
                            state <= TEXT;
                        end
                    end
                end
                TEXT: begin
                    if (xfer) begin
                        if (in_data == 8'h00) begin
                            state    <= DONE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            full     <= 1'b0;
                        end else begin
                            txt_we   <= 1'b1;
                            txt_addr <= txt_len;
                            txt_data <= in_data;
                            if (txt_len == TXT_LAST) begin
                                state    <= DONE;
                                in_ready <= 1'b0;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                                full     <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_loader.sv
// Directed self-checking bench for text_loader (default and TEXT_MAX=8 builds).
module tb_text_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;

    logic        in_ready, pat_we, txt_we, busy, done, full;
    logic [2:0]  pat_addr;
    logic [7:0]  pat_data, txt_data;
    logic [13:0] txt_addr, txt_len;

    logic        in_ready8, pat_we8, txt_we8, busy8, done8, full8;
    logic [2:0]  pat_addr8;
    logic [7:0]  pat_data8, txt_data8;
    logic [13:0] txt_addr8, txt_len8;

    int tests = 0;
    int fails = 0;

    logic [2:0]  pat_a[$];
    logic [7:0]  pat_d[$];
    logic [13:0] txt_a[$];
    logic [7:0]  txt_d[$];
    logic [13:0] txt8_a[$];
    logic [7:0]  txt8_d[$];
    int          done_cnt = 0;
    int          done8_cnt = 0;

    always #5 clk = ~clk;

    text_loader dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .pat_we(pat_we), .pat_addr(pat_addr), .pat_data(pat_data),
        .txt_we(txt_we), .txt_addr(txt_addr), .txt_data(txt_data), .txt_len(txt_len),
        .busy(busy), .done(done), .full(full)
    );

    text_loader #(.TEXT_MAX(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready8), .pat_we(pat_we8), .pat_addr(pat_addr8), .pat_data(pat_data8),
        .txt_we(txt_we8), .txt_addr(txt_addr8), .txt_data(txt_data8), .txt_len(txt_len8),
        .busy(busy8), .done(done8), .full(full8)
    );

    // Write/done logger, sampled on the falling edge.
    always @(negedge clk) begin
        if (pat_we) begin pat_a.push_back(pat_addr); pat_d.push_back(pat_data); end
        if (txt_we) begin txt_a.push_back(txt_addr); txt_d.push_back(txt_data); end
        if (txt_we8) begin txt8_a.push_back(txt_addr8); txt8_d.push_back(txt_data8); end
        if (done) done_cnt++;
        if (done8) done8_cnt++;
    end

    task automatic clear_logs();
        pat_a.delete(); pat_d.delete(); txt_a.delete(); txt_d.delete();
        txt8_a.delete(); txt8_d.delete();
        done_cnt = 0; done8_cnt = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one byte and wait (bounded) until the default DUT accepts it.
    task automatic send(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL send_timeout: byte %02h not accepted, in_ready=%0b required 1", b, in_ready);
        end else begin
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt == 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (done_cnt == 0) begin
            fails++;
            $display("FAIL done_timeout: done_cnt=%0d required >=1", done_cnt);
        end
    endtask

    task automatic check_idle_zero(input string name);
        logic [63:0] got, got8;
        got  = {in_ready, pat_we, pat_addr, pat_data, txt_we, txt_addr, txt_data, txt_len, busy, done, full};
        got8 = {in_ready8, pat_we8, pat_addr8, pat_data8, txt_we8, txt_addr8, txt_data8, txt_len8, busy8, done8, full8};
        tests++;
        if (got !== 64'd0) begin
            fails++;
            $display("FAIL %s: outputs=%h required 0", name, got);
        end
        tests++;
        if (got8 !== 64'd0) begin
            fails++;
            $display("FAIL %s_max8: outputs=%h required 0", name, got8);
        end
    endtask

    task automatic check_txt(input string name, input logic [7:0] exp[], input logic [13:0] exp_len);
        tests++;
        if (txt_a.size() != exp.size()) begin
            fails++;
            $display("FAIL %s_txt_count: got %0d writes required %0d", name, txt_a.size(), exp.size());
        end else begin
            foreach (exp[i]) begin
                tests++;
                if (txt_a[i] !== 14'(i) || txt_d[i] !== exp[i]) begin
                    fails++;
                    $display("FAIL %s_txt%0d: addr=%0d data=%02h required addr=%0d data=%02h",
                             name, i, txt_a[i], txt_d[i], i, exp[i]);
                end
            end
        end
        tests++;
        if (txt_len !== exp_len) begin
            fails++;
            $display("FAIL %s_txt_len: got %0d required %0d", name, txt_len, exp_len);
        end
    endtask

    task automatic check_pat(input string name, input logic [7:0] exp[]);
        tests++;
        if (pat_a.size() != 4) begin
            fails++;
            $display("FAIL %s_pat_count: got %0d writes required 4", name, pat_a.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (pat_a[i] !== 3'(i) || pat_d[i] !== exp[i]) begin
                    fails++;
                    $display("FAIL %s_pat%0d: addr=%0d data=%02h required addr=%0d data=%02h",
                             name, i, pat_a[i], pat_d[i], i, exp[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        check_idle_zero("reset");
    endtask

    task automatic test_basic();
        logic [7:0] pat[] = '{8'h61, 8'h62, 8'h63, 8'h64};
        logic [7:0] txt[] = '{8'h48, 8'h69};
        apply_reset();
        do_start();
        tests++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL basic_enter: in_ready=%0b busy=%0b required 1 1", in_ready, busy);
        end
        send(8'h61);
        tests++;
        if (pat_we !== 1'b1 || pat_addr !== 3'd0 || pat_data !== 8'h61) begin
            fails++;
            $display("FAIL basic_latency: we=%0b addr=%0d data=%02h required 1 0 61", pat_we, pat_addr, pat_data);
        end
        send(8'h62); send(8'h63); send(8'h64);
        send(8'h48); send(8'h69); send(8'h00);
        wait_done();
        @(negedge clk);
        @(negedge clk);
        check_pat("basic", pat);
        check_txt("basic", txt, 14'd2);
        tests++;
        if (done_cnt != 1 || full !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL basic_end: done_cnt=%0d full=%0b busy=%0b in_ready=%0b required 1 0 0 0",
                     done_cnt, full, busy, in_ready);
        end
    endtask

    task automatic test_pattern_zero();
        logic [7:0] pat[] = '{8'h00, 8'h41, 8'h00, 8'h42};
        logic [7:0] txt[] = new[0];
        apply_reset();
        do_start();
        send(8'h00); send(8'h41); send(8'h00); send(8'h42);
        send(8'h00);
        wait_done();
        @(negedge clk);
        check_pat("patzero", pat);
        check_txt("patzero", txt, 14'd0);
        tests++;
        if (done_cnt != 1 || full !== 1'b0) begin
            fails++;
            $display("FAIL patzero_end: done_cnt=%0d full=%0b required 1 0", done_cnt, full);
        end
    endtask

    task automatic test_full();
        int acc = 0;
        logic ready_after = 1'b1;
        apply_reset();
        do_start();
        send(8'h31); send(8'h32); send(8'h33); send(8'h34);
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h80 + i);
            if (acc == 8) ready_after = ready_after & ~in_ready8 ? ready_after : 1'b0;
            if (acc == 8 && in_ready8) ready_after = 1'b0;
            if (in_ready8) acc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (acc != 8) begin
            fails++;
            $display("FAIL full_accepted: got %0d bytes required 8", acc);
        end
        tests++;
        if (ready_after !== 1'b1) begin
            fails++;
            $display("FAIL full_ready_drop: in_ready8 stayed high after 8th byte, required 0");
        end
        tests++;
        if (txt8_a.size() != 8) begin
            fails++;
            $display("FAIL full_writes: got %0d required 8", txt8_a.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                tests++;
                if (txt8_a[i] !== 14'(i) || txt8_d[i] !== 8'(8'h80 + i)) begin
                    fails++;
                    $display("FAIL full_txt%0d: addr=%0d data=%02h required addr=%0d data=%02h",
                             i, txt8_a[i], txt8_d[i], i, 8'(8'h80 + i));
                end
            end
        end
        tests++;
        if (full8 !== 1'b1 || txt_len8 !== 14'd8 || done8_cnt != 1 || busy8 !== 1'b0) begin
            fails++;
            $display("FAIL full_end: full=%0b txt_len=%0d done_cnt=%0d busy=%0b required 1 8 1 0",
                     full8, txt_len8, done8_cnt, busy8);
        end
    endtask

    task automatic test_stall();
        logic [7:0] pat[] = '{8'h61, 8'h62, 8'h63, 8'h64};
        logic [7:0] txt[] = '{8'h48, 8'h69};
        logic [7:0] bytes[] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h48, 8'h69, 8'h00};
        apply_reset();
        do_start();
        foreach (bytes[i]) begin
            send(bytes[i]);
            if (i == 6) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end else begin
                start = (i >= 4);
                @(negedge clk);
                start = 1'b0;
            end
        end
        @(negedge clk);
        @(negedge clk);
        check_pat("stall", pat);
        check_txt("stall", txt, 14'd2);
        tests++;
        if (done_cnt != 1 || busy !== 1'b0 || in_ready !== 1'b0 || full !== 1'b0) begin
            fails++;
            $display("FAIL stall_end: done_cnt=%0d busy=%0b in_ready=%0b full=%0b required 1 0 0 0",
                     done_cnt, busy, in_ready, full);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] txt[] = '{8'h55};
        apply_reset();
        do_start();
        send(8'h11); send(8'h12); send(8'h13); send(8'h14);
        send(8'h21); send(8'h22); send(8'h23);
        rst = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h24;
        @(negedge clk);
        check_idle_zero("midreset");
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (txt_we !== 1'b0 || pat_we !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL midreset_discard: txt_we=%0b pat_we=%0b busy=%0b required 0 0 0", txt_we, pat_we, busy);
        end
        clear_logs();
        do_start();
        send(8'h11); send(8'h12); send(8'h13); send(8'h14);
        send(8'h55); send(8'h00);
        wait_done();
        @(negedge clk);
        check_txt("restart", txt, 14'd1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pattern_zero();
        test_full();
        test_reset();
        test_stall();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/text_loader.md
TEXT_LOADER -- requirements
Module: text_loader

Interface
REQ-001 Parameter PAT_LEN, default 4: pattern bytes captured before text.
REQ-002 Parameter TEXT_MAX, default 11064: text memory capacity in bytes.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  begin a load session; sampled in IDLE only.
REQ-006 in_valid  input  1  byte-stream valid.
REQ-007 in_data  input  8  byte-stream data.
REQ-008 in_ready  output  1  loader accepts a byte; transfer when in_valid & in_ready.
REQ-009 pat_we  output  1  pattern memory write strobe.
REQ-010 pat_addr  output  3  pattern memory address.
REQ-011 pat_data  output  8  pattern memory write data.
REQ-012 txt_we  output  1  text memory write strobe.
REQ-013 txt_addr  output  14  text memory address.
REQ-014 txt_data  output  8  text memory write data.
REQ-015 txt_len  output  14  text bytes written in the last or current session.
REQ-016 busy  output  1  high in PATTERN or TEXT.
REQ-017 done  output  1  one-cycle pulse at session end.
REQ-018 full  output  1  last session ended on TEXT_MAX, not on terminator.

Function
REQ-019 FSM states IDLE, PATTERN, TEXT, DONE; one transition max per cycle.
REQ-020 IDLE: in_ready=0; start=1 -> PATTERN, clears byte counters, txt_len and full.
REQ-021 PATTERN: in_ready=1; each transfer writes in_data verbatim (0x00 included) at pat_addr = pattern count; after transfer PAT_LEN -> TEXT.
REQ-022 TEXT: in_ready=1; transfer of 0x00 is the terminator: not written, -> DONE, full=0.
REQ-023 TEXT: non-zero transfer written at txt_addr = txt_len, then txt_len increments.
REQ-024 TEXT: write that makes txt_len = TEXT_MAX -> DONE, full=1; in_ready drops the following cycle.
REQ-025 DONE: in_ready=0, done=1 for exactly one cycle, -> IDLE unconditionally.
REQ-026 Write latency: pat_we/txt_we, address, data registered, asserted the cycle after the transfer, one cycle per byte.
REQ-027 Back-to-back transfers every cycle supported; in_valid low stalls without state change.
REQ-028 start while busy or in DONE: ignored.
REQ-029 txt_len and full hold after DONE until next accepted start.
REQ-030 Counters never wrap: pattern count saturates at PAT_LEN, txt_len at TEXT_MAX.

Reset
REQ-031 rst=1 at any clock, including mid-session: state IDLE, all outputs 0 (in_ready, pat_we, pat_addr, pat_data, txt_we, txt_addr, txt_data, txt_len, busy, done, full).
REQ-032 A transfer coincident with rst is discarded; no write strobe follows.

Structure
REQ-033 Shared package loader_pkg: state enum, PAT_LEN, TEXT_MAX, address widths 3 and 14.
REQ-034 One sub-module load_counter: parameterised-width counter with synchronous clear, enable, saturate-at-limit; instanced for pattern count and txt_len.

Verification
REQ-035 Start, stream 0x61 0x62 0x63 0x64 0x48 0x69 0x00 -> pat writes addr 0..3 = 61..64; txt writes addr 0=48, 1=69; txt_len=2, done pulse, full=0.
REQ-036 Pattern 0x00 0x41 0x00 0x42 then terminator -> all four pattern bytes written, txt_len=0, done.
REQ-037 TEXT_MAX=8 override, 12 non-zero text bytes -> 8 writes addr 0..7, full=1, in_ready low after 8th, remaining 4 bytes not accepted.
REQ-038 in_valid toggled every other cycle plus start pulses during TEXT -> identical memory contents to REQ-035, starts ignored.
REQ-039 rst asserted cycle after third text byte -> next cycle all outputs 0, IDLE; new session restarts at addr 0.
